// File: rtl/sn_to_bin_dsc.sv
// Stochastic-to-binary converter: counts 1s of a DSC/unary bitstream over one SNG frame
// and presents the saturated count through a one-entry valid/ready output register.
module sn_to_bin_dsc #(
  parameter int WIDTH  = 4,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [STRIDE-1:0] sn_in,
  input  logic              frame_end,
  output logic [WIDTH-1:0]  bin_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sat_flag,
  output logic              drop_err
);

  localparam logic [WIDTH+1:0] RES_MAX = {2'b00, {WIDTH{1'b1}}};
  localparam logic [WIDTH+1:0] ACC_MAX = {1'b0, {(WIDTH+1){1'b1}}};

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   acc, acc_nxt, pc;
  logic [WIDTH+1:0] total;
  logic [WIDTH-1:0] bin_nxt, res;
  logic             sat_nxt, drop_nxt, res_sat, close;

  always_comb begin
    pc = '0;
    for (int i = 0; i < STRIDE; i++) begin
      pc = pc + {{WIDTH{1'b0}}, sn_in[i]};
    end
  end

  assign total   = {1'b0, acc} + {1'b0, pc};
  assign res_sat = (total > RES_MAX);
  assign res     = res_sat ? {WIDTH{1'b1}} : total[WIDTH-1:0];
  assign close   = en & frame_end & ~clear;

  assign out_valid = (state == FULL);

  // The accumulator clamps instead of wrapping so a missing frame_end still reads as saturated.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    bin_nxt   = bin_out;
    sat_nxt   = sat_flag;
    drop_nxt  = drop_err;
    if (clear) begin
      acc_nxt   = '0;
      state_nxt = EMPTY;
      sat_nxt   = 1'b0;
      drop_nxt  = 1'b0;
    end else begin
      if (en) begin
        if (frame_end) begin
          acc_nxt = '0;
        end else if (total > ACC_MAX) begin
          acc_nxt = ACC_MAX[WIDTH:0];
        end else begin
          acc_nxt = total[WIDTH:0];
        end
      end
      case (state)
        EMPTY: begin
          if (close) begin
            state_nxt = FULL;
            bin_nxt   = res;
            sat_nxt   = res_sat;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (close) begin
              bin_nxt = res;
              sat_nxt = res_sat;
            end else begin
              state_nxt = EMPTY;
            end
          end else if (close) begin
            drop_nxt = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      acc      <= '0;
      bin_out  <= '0;
      sat_flag <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      bin_out  <= bin_nxt;
      sat_flag <= sat_nxt;
      drop_err <= drop_nxt;
    end
  end

endmodule

// File: doc/sn_to_bin_dsc.md
Name: sn_to_bin_dsc

Overview:
Stochastic-to-binary converter that sits directly downstream of the DSC stochastic number generator (SNG). It counts the 1s in a unary/DSC bitstream over one SNG frame. A frame is delimited by the SNG counter overflow. At the end of each frame it presents the count as a WIDTH-bit binary value through a valid/ready output register, so arithmetic results computed in the SN domain (AND/OR min/max trees) can be read back as binary.

Parameters:
WIDTH, 4, binary precision; SNG frame length is 2^WIDTH values
STRIDE, 1, SN bits consumed per cycle; legal values 1, 2, 4 only (matches the SNG stride); frame length is 2^WIDTH/STRIDE cycles

Ports:
clk  in  1  clock; all state is updated on the rising edge
rst  in  1  reset; asynchronous and active-high
en  in  1  advance enable; tie to the same en as the SNG; sn_in and frame_end are ignored when low
clear  in  1  synchronous flush: clears acc, out_valid, sat_flag and drop_err (priority below rst, above everything else)
sn_in  in  STRIDE  SN bits for this cycle; bit0 is the lowest counter position (SNG sn_out)
frame_end  in  1  high on the last cycle of a frame (SNG ctr_overflow)
bin_out  out  WIDTH  converted frame count
out_valid  out  1  bin_out holds an unconsumed result
out_ready  in  1  consumer accepts bin_out when out_valid && out_ready
sat_flag  out  1  held result was saturated; qualifies bin_out
drop_err  out  1  sticky: a completed frame was discarded because of backpressure

Behaviour:
- Reset (async, rst=1): acc=0, bin_out=0, out_valid=0, sat_flag=0, drop_err=0. The SNG shares rst, so both restart frame-aligned. Reset mid-frame discards the partial count; no output is produced for that frame.
- Popcount pc = number of 1s in sn_in (0..STRIDE). Accumulator acc is WIDTH+1 bits wide internally.
- Cycle with en=1, frame_end=0: acc <= acc + pc.
- Cycle with en=1, frame_end=1 (frame close): the current bits are included. total = acc + pc, and acc <= 0 on the same edge. Result = min(total, 2^WIDTH-1); res_sat = (total > 2^WIDTH-1).
- Cycle with en=0: acc and the frame state hold. Output handshake still operates.
- Output register, two states, EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY + frame close -> load bin_out = result and sat_flag = res_sat; go FULL the next cycle. Latency is 1 cycle after the frame_end edge.
  - FULL + out_ready + no close -> EMPTY. bin_out keeps its last value.
  - FULL + out_ready + frame close on the same cycle -> old value consumed, new value loaded, stays FULL, no drop.
  - FULL + !out_ready + frame close -> new result discarded, old value held, drop_err <= 1 (sticky until rst or clear).
- bin_out and sat_flag are stable while out_valid=1 && !out_ready.
- clear=1: acc <= 0, EMPTY, sat_flag <= 0, drop_err <= 0. A frame_end on the same cycle is ignored.
- frame_end asserted while en=0 is ignored.
- No combinational path from sn_in or out_ready to any output. All outputs are registered.

Test Plan:
- WIDTH=4, STRIDE=1, SNG bin_in=5, en=1, out_ready=1 -> frame_end on cycle 16; the following cycle gives out_valid=1, bin_out=5, sat_flag=0 for 1 cycle. The next frame repeats with value 5.
- WIDTH=4, STRIDE=4, SNG bin_in=11 -> frame of 4 cycles with popcounts 4,4,3,0 -> bin_out=11. Also sweep bin_in=0..15 and require bin_out == bin_in for each frame.
- Backpressure: out_ready=0; frame A value 5, then frame B value 9 -> bin_out stays 5, drop_err=1 after B closes. Then out_ready=1 -> 5 is consumed, out_valid=0, drop_err stays 1 until clear.
- Simultaneous: out_valid=1 (value 3) with out_ready=1 on the frame_end cycle of a value-7 frame -> next cycle out_valid=1, bin_out=7, drop_err=0.
- Saturation and en gating: force sn_in=1 for all 16 cycles, with en dropped for 5 cycles mid-frame (acc holds) -> bin_out=15, sat_flag=1.
- Reset and clear: assert rst asynchronously at cycle 7 of a frame -> all outputs 0 immediately, and the next full frame reports the correct value. Assert clear with out_valid=1 -> out_valid=0 and acc=0 on the next cycle.
